uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_parity_calc.sv | 14 +
 rtl/uart_tx_core.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter state encoding and parity-type constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - even/odd parity bit over one data word
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  par_bit
);

  assign par_bit = (par_type == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter with one-entry holding register and per-word framing
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e state_q, state_nxt;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;
  logic                  hold_stop2;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  frame_par_en;
  logic                  frame_stop2;
  logic                  par_q;
  logic                  tx_q;

  logic tx_nxt;
  logic load;
  logic shift_en;
  logic frame_end;
  logic accept;
  logic par_calc;

  assign accept     = DATA_VALID && !hold_full;
  assign DATA_READY = !hold_full;
  assign BUSY       = (state_q != ST_IDLE) || hold_full;
  assign TX_OUT     = tx_q;
  assign FRAME_DONE = frame_end;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data     (hold_data),
    .par_type (hold_par_typ),
    .par_bit  (par_calc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // tx_nxt is the level of the bit that begins at this edge, keeping TX_OUT a pure flop
  always_comb begin
    state_nxt = state_q;
    tx_nxt    = tx_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TICK && hold_full) begin
          load      = 1'b1;
          state_nxt = ST_START;
          tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (TICK) begin
          state_nxt = ST_DATA;
          tx_nxt    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (TICK) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_nxt = frame_par_en ? ST_PARITY : ST_STOP1;
            tx_nxt    = frame_par_en ? par_q : 1'b1;
          end else begin
            tx_nxt = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (TICK) begin
          state_nxt = ST_STOP1;
          tx_nxt    = 1'b1;
        end
      end
      ST_STOP1: begin
        if (TICK) begin
          if (frame_stop2) begin
            state_nxt = ST_STOP2;
            tx_nxt    = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (TICK) frame_end = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
    if (frame_end) begin
      if (hold_full) begin
        load      = 1'b1;
        state_nxt = ST_START;
        tx_nxt    = 1'b0;
      end else begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    end
  end

  // Load and accept are mutually exclusive: load needs a full holder, accept an empty one
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_stop2   <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full    <= 1'b1;
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
      hold_stop2   <= STOP2;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      frame_par_en <= 1'b0;
      frame_stop2  <= 1'b0;
      par_q        <= 1'b0;
    end else if (load) begin
      shift_q      <= hold_data;
      cnt_q        <= '0;
      frame_par_en <= hold_par_en;
      frame_stop2  <= hold_stop2;
      par_q        <= par_calc;
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
      cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - scoreboard bench for uart_tx_core at 8 and 5 data bits
module tb_uart_tx_core;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          b2b;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       TICK = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic       sel5 = 1'b0;

  logic valid8, valid5;
  logic rdy8, tx8, busy8, fd8;
  logic rdy5, tx5, busy5, fd5;
  logic mon_rdy, mon_tx, mon_busy, mon_fd;

  assign valid8   = DATA_VALID & ~sel5;
  assign valid5   = DATA_VALID & sel5;
  assign mon_rdy  = sel5 ? rdy5  : rdy8;
  assign mon_tx   = sel5 ? tx5   : tx8;
  assign mon_busy = sel5 ? busy5 : busy8;
  assign mon_fd   = sel5 ? fd5   : fd8;

  uart_tx_core #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA), .DATA_VALID(valid8),
    .DATA_READY(rdy8), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx8), .BUSY(busy8), .FRAME_DONE(fd8)
  );

  uart_tx_core #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA[4:0]), .DATA_VALID(valid5),
    .DATA_READY(rdy5), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx5), .BUSY(busy5), .FRAME_DONE(fd5)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  frame_t exp_q[$];
  bit     in_frame = 0;
  int     tick_idx = 0;
  int     last_end = -10;
  int     max_cnt5 = 0;

  initial forever #5 CLK = ~CLK;

  initial begin
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK);
        #1;
        TICK = (i == 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t build(input logic [7:0] d, input int w, input bit pen,
                                   input bit ptyp, input bit st2, input bit b2b);
    frame_t     f;
    logic [7:0] dd;
    logic       p;
    f.bits = '0;
    f.n    = 1;
    f.b2b  = b2b;
    dd     = d;
    p      = 1'b0;
    for (int i = 0; i < w; i++) begin
      f.bits = f.bits | (16'(dd[0]) << f.n);
      p      = p ^ dd[0];
      dd     = dd >> 1;
      f.n++;
    end
    if (pen) begin
      f.bits = f.bits | (16'(p ^ ptyp) << f.n);
      f.n++;
    end
    f.bits = f.bits | (16'd1 << f.n);
    f.n++;
    if (st2) begin
      f.bits = f.bits | (16'd1 << f.n);
      f.n++;
    end
    return f;
  endfunction

  // Samples the line on every TICK cycle, i.e. the last cycle of each bit
  initial begin
    frame_t      cur;
    int          nb;
    int          fdc;
    logic [15:0] got;
    nb  = 0;
    fdc = 0;
    got = '0;
    cur.bits = '0;
    cur.n    = 0;
    cur.b2b  = 0;
    forever begin
      @(negedge CLK);
      if (sel5 && int'(dut5.cnt_q) > max_cnt5) max_cnt5 = int'(dut5.cnt_q);
      if (!RST) begin
        in_frame = 0;
      end else if (TICK) begin
        tick_idx++;
        if (!in_frame) begin
          if (mon_fd) check_eq("stray_frame_done", 32'(mon_fd), 32'd0);
          if (mon_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
              check_eq("unexpected_frame", 32'(exp_q.size()), 32'd1);
            end else begin
              cur      = exp_q.pop_front();
              in_frame = 1;
              nb       = 0;
              fdc      = 0;
              got      = '0;
              if (cur.b2b) check_eq("b2b_gap", 32'(tick_idx), 32'(last_end + 1));
            end
          end
        end
        if (in_frame) begin
          got = got | (16'(mon_tx) << nb);
          if (mon_fd) fdc++;
          nb++;
          if (nb == cur.n) begin
            check_eq("frame_bits", 32'(got), 32'(cur.bits));
            check_eq("frame_done_last", 32'(mon_fd), 32'd1);
            check_eq("frame_done_count", 32'(fdc), 32'd1);
            last_end = tick_idx;
            in_frame = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit pen, input bit ptyp, input bit st2,
                      input bit push, input bit b2b, input int w);
    int i;
    @(posedge CLK);
    #1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    STOP2      = st2;
    DATA_VALID = 1'b1;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (mon_rdy) break;
    end
    check_eq("accept_wait", 32'(i < 3000), 32'd1);
    if (push) exp_q.push_back(build(d, w, pen, ptyp, st2, b2b));
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    P_DATA     = ~d;
    PAR_EN     = ~pen;
    PAR_TYP    = ~ptyp;
    STOP2      = ~st2;
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !in_frame && !mon_busy) break;
    end
    check_eq(tag, 32'(i < 3000), 32'd1);
  endtask

  task automatic wait_fall();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (mon_tx == 1'b0) break;
    end
    check_eq("wait_start_bit", 32'(i < 200), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 20; j++) begin
        @(negedge CLK);
        if (TICK) break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_eq("rst_tx8", 32'(tx8), 32'd1);
    check_eq("rst_ready8", 32'(rdy8), 32'd1);
    check_eq("rst_busy8", 32'(busy8), 32'd0);
    check_eq("rst_fd8", 32'(fd8), 32'd0);
    check_eq("rst_tx5", 32'(tx5), 32'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    send(8'hA5, 0, 0, 0, 1, 0, 8);
    drain("drain_a5");
    check_eq("busy_after_a5", 32'(busy8), 32'd0);

    send(8'h0F, 1, 0, 0, 1, 0, 8);
    drain("drain_0f_even");
    send(8'h0F, 1, 1, 0, 1, 0, 8);
    drain("drain_0f_odd");

    send(8'h00, 0, 0, 1, 1, 0, 8);
    drain("drain_stop2");

    send(8'h55, 0, 0, 0, 1, 0, 8);
    wait_fall();
    wait_ticks(2);
    send(8'h3C, 0, 0, 0, 1, 1, 8);
    @(negedge CLK);
    check_eq("ready_low_held", 32'(rdy8), 32'd0);
    check_eq("busy_held", 32'(busy8), 32'd1);
    drain("drain_b2b");

    send(8'h0F, 0, 0, 0, 1, 0, 8);
    wait_fall();
    send(8'hAA, 1, 0, 1, 0, 0, 8);
    wait_ticks(5);
    @(posedge CLK);
    #2;
    check_eq("bit4_before_reset", 32'(tx8), 32'd0);
    RST = 1'b0;
    #1;
    check_eq("midrst_tx", 32'(tx8), 32'd1);
    check_eq("midrst_ready", 32'(rdy8), 32'd1);
    check_eq("midrst_busy", 32'(busy8), 32'd0);
    check_eq("midrst_fd", 32'(fd8), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) @(negedge CLK);
    check_eq("held_discarded_busy", 32'(busy8), 32'd0);
    send(8'h96, 1, 1, 0, 1, 0, 8);
    drain("drain_after_reset");

    sel5 = 1'b1;
    send(8'h13, 1, 1, 0, 1, 0, 5);
    drain("drain_w5_odd");
    send(8'h0A, 1, 0, 1, 1, 0, 5);
    drain("drain_w5_stop2");
    check_eq("cnt_max5_le4", 32'(max_cnt5 <= 4), 32'd1);

    repeat (4) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
